// File: rtl/xsip_module_sequencer_if.sv
// ----------------------------------------------------------------------------
// xsip_module_sequencer_if
// Start/ready handshake bundle between the XSIP module sequencer and the
// XR modules it brings up (index 0 = xrad ... 5 = xrst).
//   mod_start  : per-module start request (level), driven by the sequencer
//   modules_up : per-module "acknowledged" flags, driven by the sequencer
//   mod_ready  : per-module ready acknowledge, driven by the modules
// Modports: master = sequencer side, slave = module side.
// ----------------------------------------------------------------------------
interface xsip_module_sequencer_if #(
    parameter int unsigned NUM_MODULES = 6
);
    logic [NUM_MODULES-1:0] mod_start;
    logic [NUM_MODULES-1:0] modules_up;
    logic [NUM_MODULES-1:0] mod_ready;

    modport master (
        output mod_start,
        output modules_up,
        input  mod_ready
    );

    modport slave (
        input  mod_start,
        input  modules_up,
        output mod_ready
    );
endinterface

// File: rtl/xsip_module_sequencer.sv
// ----------------------------------------------------------------------------
// xsip_module_sequencer
// Brings up the enabled XR modules one at a time after the XSIP activation
// stage completes, with a per-attempt timeout and bounded retries, and tears
// them down in reverse order when activation drops.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   activation_complete : level; rising edge (seen in IDLE) starts bring-up
//   en_in               : module enables, latched on the trigger
//   mod_if (master)     : mod_start / modules_up out, mod_ready in
//   seq_state           : current state code (IDLE=0 ... TEARDOWN=7)
//   seq_done            : all enabled modules are up
//   seq_fault           : a module exhausted its retries
//   fault_id            : index of the failing module
//   bringup_cycles      : cycles from trigger to DONE (saturating)
// ----------------------------------------------------------------------------
module xsip_module_sequencer #(
    parameter int unsigned NUM_MODULES    = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   activation_complete,
    input  logic [NUM_MODULES-1:0] en_in,
    xsip_module_sequencer_if.master mod_if,
    output logic [7:0]             seq_state,
    output logic                   seq_done,
    output logic                   seq_fault,
    output logic [7:0]             fault_id,
    output logic [31:0]            bringup_cycles
);
    localparam int unsigned IW = $clog2(NUM_MODULES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    localparam logic [IW-1:0] IDX_END      = IW'(NUM_MODULES);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_MODULES - 1);
    localparam logic [TW-1:0] TIMER_TO     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SETTLE = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        START    = 3'd2,
        RETRY    = 3'd3,
        SETTLE   = 3'd4,
        DONE     = 3'd5,
        FAULT    = 3'd6,
        TEARDOWN = 3'd7
    } state_t;

    state_t                 state;
    logic                   act_q;
    logic [NUM_MODULES-1:0] en_lat;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          tidx;
    logic [TW-1:0]          timer;
    logic [RW-1:0]          retry_cnt;
    logic [31:0]            cyc_cnt;
    logic [NUM_MODULES-1:0] mod_start_q;
    logic [NUM_MODULES-1:0] modules_up_q;

    logic                   rise;
    logic [NUM_MODULES-1:0] sel;
    logic [NUM_MODULES-1:0] tsel;
    logic                   ready_hit;

    // One-hot masks avoid indexing with idx when idx == NUM_MODULES
    // (the "all done" value), where sel simply becomes zero.
    always_comb begin
        rise      = activation_complete & ~act_q;
        sel       = NUM_MODULES'(1) << idx;
        tsel      = NUM_MODULES'(1) << tidx;
        ready_hit = |(mod_if.mod_ready & sel);
    end

    assign mod_if.mod_start  = mod_start_q;
    assign mod_if.modules_up = modules_up_q;
    assign seq_state         = 8'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            act_q          <= 1'b0;
            en_lat         <= '0;
            idx            <= '0;
            tidx           <= '0;
            timer          <= '0;
            retry_cnt      <= '0;
            cyc_cnt        <= '0;
            mod_start_q    <= '0;
            modules_up_q   <= '0;
            seq_done       <= 1'b0;
            seq_fault      <= 1'b0;
            fault_id       <= '0;
            bringup_cycles <= '0;
        end else begin
            act_q <= activation_complete;
            if (cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        en_lat    <= en_in;
                        idx       <= '0;
                        timer     <= '0;
                        retry_cnt <= '0;
                        cyc_cnt   <= '0;
                        fault_id  <= '0;
                        state     <= SELECT;
                    end
                end

                FAULT: begin
                    if (!activation_complete) begin
                        seq_fault <= 1'b0;
                        state     <= IDLE;
                    end
                end

                TEARDOWN: begin
                    mod_start_q  <= mod_start_q & ~tsel;
                    modules_up_q <= modules_up_q & ~tsel;
                    if (tidx == '0) begin
                        state <= IDLE;
                    end else begin
                        tidx <= tidx - 1'b1;
                    end
                end

                default: begin
                    // Loss of activation outranks ready, timeout and settle.
                    if (!activation_complete) begin
                        seq_done <= 1'b0;
                        tidx     <= IDX_LAST;
                        state    <= TEARDOWN;
                    end else begin
                        case (state)
                            SELECT: begin
                                if (idx == IDX_END) begin
                                    seq_done       <= 1'b1;
                                    bringup_cycles <= (cyc_cnt == '1) ? '1 : cyc_cnt + 32'd1;
                                    state          <= DONE;
                                end else if ((en_lat & sel) == '0) begin
                                    idx <= idx + 1'b1;
                                end else begin
                                    timer       <= '0;
                                    mod_start_q <= mod_start_q | sel;
                                    state       <= START;
                                end
                            end

                            START: begin
                                if (ready_hit) begin
                                    modules_up_q <= modules_up_q | sel;
                                    timer        <= '0;
                                    state        <= SETTLE;
                                end else if (timer == TIMER_TO) begin
                                    if (retry_cnt < RETRY_MAX) begin
                                        mod_start_q <= mod_start_q & ~sel;
                                        retry_cnt   <= retry_cnt + 1'b1;
                                        state       <= RETRY;
                                    end else begin
                                        seq_fault    <= 1'b1;
                                        fault_id     <= 8'(idx);
                                        mod_start_q  <= '0;
                                        modules_up_q <= '0;
                                        state        <= FAULT;
                                    end
                                end else begin
                                    timer <= timer + 1'b1;
                                end
                            end

                            RETRY: begin
                                timer       <= '0;
                                mod_start_q <= mod_start_q | sel;
                                state       <= START;
                            end

                            SETTLE: begin
                                if (timer == TIMER_SETTLE) begin
                                    timer     <= '0;
                                    idx       <= idx + 1'b1;
                                    retry_cnt <= '0;
                                    state     <= SELECT;
                                end else begin
                                    timer <= timer + 1'b1;
                                end
                            end

                            default: begin
                                // DONE holds while activation stays high.
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xsip_module_sequencer.sv
// ----------------------------------------------------------------------------
// tb_xsip_module_sequencer
// Directed bench for xsip_module_sequencer. A small responder raises
// mod_ready[i] once mod_start[i] has been high for more than dly[i] samples;
// extra_rdy forces ready pulses regardless of mod_start.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xsip_module_sequencer;
    localparam int unsigned N     = 6;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        act = 1'b0;
    logic [5:0]  en_in = '0;
    logic [7:0]  seq_state;
    logic        seq_done;
    logic        seq_fault;
    logic [7:0]  fault_id;
    logic [31:0] bringup_cycles;

    int unsigned dly [N];
    int unsigned start_cnt [N];
    logic [N-1:0] rdy_rule = '0;
    logic [N-1:0] extra_rdy = '0;

    int checks = 0;
    int failures = 0;

    xsip_module_sequencer_if #(.NUM_MODULES(N)) mif ();

    xsip_module_sequencer #(
        .NUM_MODULES   (N),
        .TIMEOUT_CYCLES(1024),
        .SETTLE_CYCLES (4),
        .MAX_RETRY     (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .activation_complete(act),
        .en_in              (en_in),
        .mod_if             (mif),
        .seq_state          (seq_state),
        .seq_done           (seq_done),
        .seq_fault          (seq_fault),
        .fault_id           (fault_id),
        .bringup_cycles     (bringup_cycles)
    );

    always #5 clk = ~clk;

    assign mif.mod_ready = rdy_rule | extra_rdy;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int unsigned c;
            c = (mif.mod_start[i] === 1'b1) ? start_cnt[i] + 1 : 0;
            start_cnt[i] <= c;
            rdy_rule[i]  <= (c > dly[i]);
        end
    end

    task automatic set_dly(input int unsigned d0, d1, d2, d3, d4, d5);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        dly[3] = d3; dly[4] = d4; dly[5] = d5;
    endtask

    task automatic trigger(input logic [5:0] en);
        @(negedge clk);
        en_in = en;
        act   = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seq_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drop_to_idle(output bit ok);
        @(negedge clk);
        act = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seq_state === 8'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (seq_state !== 8'd0 || seq_done !== 1'b0 || seq_fault !== 1'b0 ||
            fault_id !== 8'd0 || bringup_cycles !== 32'd0 ||
            mif.mod_start !== 6'd0 || mif.modules_up !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs: state=%0d done=%b fault=%b id=%0d cyc=%0d start=%h up=%h, expected all 0",
                     seq_state, seq_done, seq_fault, fault_id, bringup_cycles, mif.mod_start, mif.modules_up);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_all_enabled;
        bit ok;
        set_dly(3, 3, 3, 3, 3, 3);
        trigger(6'h3F);
        @(negedge clk);
        checks++;
        if (seq_state !== 8'd1 || mif.mod_start !== 6'h00) begin
            failures++;
            $display("FAIL all_select: state=%0d start=%h, expected 1 / 00", seq_state, mif.mod_start);
        end
        @(negedge clk);
        checks++;
        if (seq_state !== 8'd2 || mif.mod_start !== 6'h01) begin
            failures++;
            $display("FAIL all_first_start: state=%0d start=%h, expected 2 / 01", seq_state, mif.mod_start);
        end
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL all_done_timeout: seq_done=%b after 200 cycles, expected 1", seq_done);
        end
        checks++;
        if (seq_state !== 8'd5 || mif.modules_up !== 6'h3F || mif.mod_start !== 6'h3F ||
            bringup_cycles !== 32'd55) begin
            failures++;
            $display("FAIL all_final: state=%0d up=%h start=%h cyc=%0d, expected 5 / 3f / 3f / 55",
                     seq_state, mif.modules_up, mif.mod_start, bringup_cycles);
        end
    endtask

    task automatic test_teardown;
        logic [5:0] exp_bits;
        @(negedge clk);
        act = 1'b0;
        @(negedge clk);
        checks++;
        if (seq_state !== 8'd7 || seq_done !== 1'b0 || mif.mod_start !== 6'h3F) begin
            failures++;
            $display("FAIL td_entry: state=%0d done=%b start=%h, expected 7 / 0 / 3f",
                     seq_state, seq_done, mif.mod_start);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_bits = 6'h3F >> k;
            checks++;
            if (mif.mod_start !== exp_bits || mif.modules_up !== exp_bits ||
                seq_state !== ((k == 6) ? 8'd0 : 8'd7)) begin
                failures++;
                $display("FAIL td_step%0d: start=%h up=%h state=%0d, expected %h / %h / %0d",
                         k, mif.mod_start, mif.modules_up, seq_state, exp_bits, exp_bits,
                         (k == 6) ? 0 : 7);
            end
        end
    endtask

    task automatic test_sparse;
        bit ok;
        logic [5:0] seen = '0;
        set_dly(0, 0, 0, 0, 0, 0);
        trigger(6'b100101);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            seen = seen | mif.mod_start;
            if (seq_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sparse_done_timeout: seq_done=%b, expected 1", seq_done);
        end
        checks++;
        if (seen !== 6'b100101 || mif.modules_up !== 6'b100101 || bringup_cycles !== 32'd22) begin
            failures++;
            $display("FAIL sparse_result: seen_start=%b up=%b cyc=%0d, expected 100101 / 100101 / 22",
                     seen, mif.modules_up, bringup_cycles);
        end
        drop_to_idle(ok);
        checks++;
        if (!ok || mif.mod_start !== 6'd0) begin
            failures++;
            $display("FAIL sparse_idle: state=%0d start=%h, expected 0 / 00", seq_state, mif.mod_start);
        end
    endtask

    task automatic test_timeout_fault;
        bit ok;
        int h;
        set_dly(0, 0, 0, NEVER, 0, 0);
        trigger(6'h3F);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mif.mod_start[3] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || mif.modules_up !== 6'h07) begin
            failures++;
            $display("FAIL fault_reach_m3: started=%b up=%h, expected 1 / 07", ok, mif.modules_up);
        end
        for (int w = 0; w < 3; w++) begin
            h = 0;
            while (mif.mod_start[3] === 1'b1 && h < 3000) begin
                h++;
                @(negedge clk);
            end
            checks++;
            if (h != 1024) begin
                failures++;
                $display("FAIL fault_window%0d: high for %0d cycles, expected 1024", w, h);
            end
            if (w < 2) begin
                checks++;
                if (seq_state !== 8'd3 || mif.modules_up !== 6'h07) begin
                    failures++;
                    $display("FAIL fault_retry%0d: state=%0d up=%h, expected 3 / 07", w, seq_state, mif.modules_up);
                end
                @(negedge clk);
                checks++;
                if (mif.mod_start[3] !== 1'b1 || seq_state !== 8'd2) begin
                    failures++;
                    $display("FAIL fault_gap%0d: start3=%b state=%0d after 1 low cycle, expected 1 / 2",
                             w, mif.mod_start[3], seq_state);
                end
            end
        end
        checks++;
        if (seq_state !== 8'd6 || seq_fault !== 1'b1 || fault_id !== 8'd3 ||
            mif.mod_start !== 6'd0 || mif.modules_up !== 6'd0 || seq_done !== 1'b0) begin
            failures++;
            $display("FAIL fault_final: state=%0d fault=%b id=%0d start=%h up=%h done=%b, expected 6 / 1 / 3 / 00 / 00 / 0",
                     seq_state, seq_fault, fault_id, mif.mod_start, mif.modules_up, seq_done);
        end
        drop_to_idle(ok);
        checks++;
        if (!ok || seq_fault !== 1'b0 || fault_id !== 8'd3) begin
            failures++;
            $display("FAIL fault_release: state=%0d fault=%b id=%0d, expected 0 / 0 / 3",
                     seq_state, seq_fault, fault_id);
        end
    endtask

    task automatic test_ready_at_boundary;
        bit ok;
        bit saw_retry;
        set_dly(0, 1023, 0, 0, 0, 0);
        trigger(6'b000010);
        @(negedge clk);
        checks++;
        if (fault_id !== 8'd0 || seq_state !== 8'd1) begin
            failures++;
            $display("FAIL edge_trigger_clear: id=%0d state=%0d, expected 0 / 1", fault_id, seq_state);
        end
        ok = 1'b0;
        saw_retry = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (seq_state === 8'd3) saw_retry = 1'b1;
            if (seq_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || saw_retry) begin
            failures++;
            $display("FAIL edge_no_retry: done=%b saw_retry=%b, expected 1 / 0", seq_done, saw_retry);
        end
        checks++;
        if (mif.modules_up !== 6'b000010 || bringup_cycles !== 32'd1035) begin
            failures++;
            $display("FAIL edge_result: up=%b cyc=%0d, expected 000010 / 1035", mif.modules_up, bringup_cycles);
        end
        drop_to_idle(ok);
    endtask

    task automatic test_abort_restart;
        bit ok;
        set_dly(0, 0, NEVER, NEVER, NEVER, NEVER);
        trigger(6'h3F);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mif.mod_start[2] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || seq_state !== 8'd2 || mif.modules_up !== 6'h03) begin
            failures++;
            $display("FAIL abort_in_start: reached=%b state=%0d up=%h, expected 1 / 2 / 03",
                     ok, seq_state, mif.modules_up);
        end
        repeat (3) @(negedge clk);
        act = 1'b0;
        @(negedge clk);
        extra_rdy = 6'h3F;
        checks++;
        if (seq_state !== 8'd7) begin
            failures++;
            $display("FAIL abort_teardown: state=%0d, expected 7", seq_state);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (seq_state !== 8'd0 || mif.mod_start !== 6'd0 || mif.modules_up !== 6'd0) begin
            failures++;
            $display("FAIL abort_ready_ignored: state=%0d start=%h up=%h, expected 0 / 00 / 00",
                     seq_state, mif.mod_start, mif.modules_up);
        end
        extra_rdy = '0;
        set_dly(0, 0, 0, 0, 0, 0);
        trigger(6'b000001);
        @(negedge clk);
        en_in = 6'h3F;
        wait_done(100, ok);
        checks++;
        if (!ok || mif.modules_up !== 6'b000001 || mif.mod_start !== 6'b000001 ||
            bringup_cycles !== 32'd12) begin
            failures++;
            $display("FAIL abort_restart: done=%b up=%b start=%b cyc=%0d, expected 1 / 000001 / 000001 / 12",
                     ok, mif.modules_up, mif.mod_start, bringup_cycles);
        end
        drop_to_idle(ok);
    endtask

    task automatic test_empty;
        bit ok;
        trigger(6'b000000);
        wait_done(50, ok);
        checks++;
        if (!ok || bringup_cycles !== 32'd7 || mif.modules_up !== 6'd0 || mif.mod_start !== 6'd0) begin
            failures++;
            $display("FAIL empty_result: done=%b cyc=%0d up=%h start=%h, expected 1 / 7 / 00 / 00",
                     ok, bringup_cycles, mif.modules_up, mif.mod_start);
        end
        drop_to_idle(ok);
    endtask

    task automatic test_reset_midop;
        set_dly(0, NEVER, NEVER, NEVER, NEVER, NEVER);
        trigger(6'h3F);
        repeat (10) @(negedge clk);
        checks++;
        if (seq_state !== 8'd2 || mif.mod_start !== 6'h03 || mif.modules_up !== 6'h01) begin
            failures++;
            $display("FAIL midop_pre: state=%0d start=%h up=%h, expected 2 / 03 / 01",
                     seq_state, mif.mod_start, mif.modules_up);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seq_state !== 8'd0 || seq_done !== 1'b0 || seq_fault !== 1'b0 || fault_id !== 8'd0 ||
            bringup_cycles !== 32'd0 || mif.mod_start !== 6'd0 || mif.modules_up !== 6'd0) begin
            failures++;
            $display("FAIL midop_reset: state=%0d done=%b fault=%b id=%0d cyc=%0d start=%h up=%h, expected all 0",
                     seq_state, seq_done, seq_fault, fault_id, bringup_cycles, mif.mod_start, mif.modules_up);
        end
        act = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_dly(NEVER, NEVER, NEVER, NEVER, NEVER, NEVER);
        for (int i = 0; i < N; i++) start_cnt[i] = 0;
        test_reset;
        test_all_enabled;
        test_teardown;
        test_sparse;
        test_timeout_fault;
        test_ready_at_boundary;
        test_abort_restart;
        test_empty;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
